// File: rtl/read_engine.sv
// Cache-line read request generator for the host c0 read channel.
// Polls the control word while in CTRL and streams sequential data reads while in RUN.
module read_engine #(
    parameter int              ADDR_W          = 42,
    parameter int              MDATA_W         = 16,
    parameter int              CNT_W           = 32,
    parameter logic [15:0]     READ_CTRL_MDATA = 16'h0001,
    parameter logic [15:0]     READ_RUN_MDATA  = 16'h0002,
    parameter int              POLL_GAP        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [2:0]         afu_state_in,
    input  logic [ADDR_W-1:0]  ctrl_addr,
    input  logic               ctrl_resp_valid,
    input  logic [ADDR_W-1:0]  ctrl_rd_addr,
    input  logic [CNT_W-1:0]   ctrl_num_cls,
    output logic               rd_valid,
    output logic [MDATA_W-1:0] rd_mdata,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [CNT_W-1:0]   run_reqs_issued
);

    typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT, P_GAP} poll_e;

    localparam logic [2:0]  ST_CTRL  = 3'd1;
    localparam logic [2:0]  ST_RUN   = 3'd2;
    // Loaded with POLL_GAP-1 so that exactly POLL_GAP idle cycles separate the
    // response pulse from the next visible control read.
    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

    poll_e               poll_q, poll_d;
    logic [15:0]         gap_q, gap_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                prev_run_q, prev_run_d;
    logic                rd_valid_q, rd_valid_d;
    logic [MDATA_W-1:0]  rd_mdata_q, rd_mdata_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    logic                in_ctrl, in_run, run_entry, poll_try;
    logic [ADDR_W-1:0]   eff_base;
    logic [CNT_W-1:0]    eff_limit, eff_cnt;

    always_comb begin
        poll_d     = poll_q;
        gap_d      = gap_q;
        base_d     = base_q;
        limit_d    = limit_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_mdata_d = rd_mdata_q;
        rd_addr_d  = rd_addr_q;
        poll_try   = 1'b0;

        in_ctrl    = (afu_state_in == ST_CTRL);
        in_run     = (afu_state_in == ST_RUN);
        run_entry  = in_run && !prev_run_q;
        prev_run_d = in_run;

        // On the entry cycle the fresh base/limit are used directly so the first
        // data read is decided in that same cycle.
        eff_base   = run_entry ? ctrl_rd_addr : base_q;
        eff_limit  = run_entry ? ctrl_num_cls : limit_q;
        eff_cnt    = run_entry ? '0 : cnt_q;

        if (!in_ctrl) begin
            poll_d = P_IDLE;
        end else begin
            case (poll_q)
                P_IDLE, P_ISSUE: poll_try = 1'b1;
                P_WAIT: begin
                    if (ctrl_resp_valid) begin
                        poll_d = P_GAP;
                        gap_d  = GAP_LOAD;
                    end
                end
                P_GAP: begin
                    if (gap_q == '0) poll_try = 1'b1;
                    else             gap_d    = gap_q - 16'd1;
                end
                default: poll_d = P_IDLE;
            endcase
            if (poll_try) begin
                if (!stall) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = ctrl_addr;
                    rd_mdata_d = MDATA_W'(READ_CTRL_MDATA);
                    poll_d     = P_WAIT;
                end else begin
                    poll_d     = P_ISSUE;
                end
            end
        end

        if (in_run) begin
            base_d  = eff_base;
            limit_d = eff_limit;
            cnt_d   = eff_cnt;
            if (!stall && (eff_cnt < eff_limit)) begin
                rd_valid_d = 1'b1;
                rd_addr_d  = eff_base + ADDR_W'(eff_cnt);
                rd_mdata_d = MDATA_W'(READ_RUN_MDATA);
                cnt_d      = eff_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_q     <= P_IDLE;
            gap_q      <= '0;
            base_q     <= '0;
            limit_q    <= '0;
            cnt_q      <= '0;
            // A RUN level held through reset is not a fresh entry.
            prev_run_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_mdata_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            poll_q     <= poll_d;
            gap_q      <= gap_d;
            base_q     <= base_d;
            limit_q    <= limit_d;
            cnt_q      <= cnt_d;
            prev_run_q <= prev_run_d;
            rd_valid_q <= rd_valid_d;
            rd_mdata_q <= rd_mdata_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign rd_valid        = rd_valid_q;
    assign rd_mdata        = rd_mdata_q;
    assign rd_addr         = rd_addr_q;
    assign run_reqs_issued = cnt_q;

endmodule

// File: tb/tb_read_engine.sv
// Scoreboard bench for read_engine: a cycle-level request model feeds an expected
// queue that a negedge monitor drains against the DUT outputs.
module tb_read_engine;

    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  afu_state_in = 3'd0;
    logic [41:0] ctrl_addr = '0;
    logic        ctrl_resp_valid = 1'b0;
    logic [41:0] ctrl_rd_addr = '0;
    logic [31:0] ctrl_num_cls = '0;
    logic        rd_valid;
    logic [15:0] rd_mdata;
    logic [41:0] rd_addr;
    logic [31:0] run_reqs_issued;

    read_engine dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .afu_state_in    (afu_state_in),
        .ctrl_addr       (ctrl_addr),
        .ctrl_resp_valid (ctrl_resp_valid),
        .ctrl_rd_addr    (ctrl_rd_addr),
        .ctrl_num_cls    (ctrl_num_cls),
        .rd_valid        (rd_valid),
        .rd_mdata        (rd_mdata),
        .rd_addr         (rd_addr),
        .run_reqs_issued (run_reqs_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          appear;
        logic [15:0] mdata;
        logic [41:0] addr;
    } req_t;

    req_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Reference model state
    bit          m_outstanding;
    int          m_poll_ok;
    bit          m_prev_run;
    logic [41:0] m_base;
    logic [31:0] m_limit;
    logic [31:0] m_issued;
    logic [41:0] m_hold_addr;
    logic [15:0] m_hold_mdata;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_req(int t, logic [15:0] md, logic [41:0] a);
        req_t r;
        r.appear = t + 1;
        r.mdata  = md;
        r.addr   = a;
        sb.push_back(r);
        m_hold_addr  = a;
        m_hold_mdata = md;
    endfunction

    always @(posedge clk) begin
        int t;
        bit is_ctrl, is_run;
        t       = cyc;
        is_ctrl = (afu_state_in == 3'd1);
        is_run  = (afu_state_in == 3'd2);
        if (reset) begin
            m_outstanding = 0;
            m_poll_ok     = 0;
            m_prev_run    = 1;
            m_base        = '0;
            m_limit       = '0;
            m_issued      = '0;
            m_hold_addr   = '0;
            m_hold_mdata  = '0;
        end else begin
            if (!is_ctrl) begin
                m_outstanding = 0;
                m_poll_ok     = 0;
            end else if (m_outstanding) begin
                if (ctrl_resp_valid) begin
                    m_outstanding = 0;
                    m_poll_ok     = t + POLL_GAP;
                end
            end else if (t >= m_poll_ok && !stall) begin
                push_req(t, 16'h0001, ctrl_addr);
                m_outstanding = 1;
            end
            if (is_run) begin
                if (!m_prev_run) begin
                    m_base   = ctrl_rd_addr;
                    m_limit  = ctrl_num_cls;
                    m_issued = '0;
                end
                if (!stall && m_issued < m_limit) begin
                    push_req(t, 16'h0002, m_base + {10'b0, m_issued});
                    m_issued = m_issued + 1;
                end
            end
            m_prev_run = is_run;
        end
        cyc = t + 1;
    end

    always @(negedge clk) begin
        bit   exp_v;
        req_t r;
        if (cyc > 0) begin
            exp_v = (sb.size() > 0 && sb[0].appear == cyc);
            chk("rd_valid", {63'b0, rd_valid}, {63'b0, exp_v});
            if (exp_v) begin
                r = sb.pop_front();
                if (rd_valid) begin
                    chk("rd_addr", {22'b0, rd_addr}, {22'b0, r.addr});
                    chk("rd_mdata", {48'b0, rd_mdata}, {48'b0, r.mdata});
                end
            end else begin
                chk("rd_addr_hold", {22'b0, rd_addr}, {22'b0, m_hold_addr});
                chk("rd_mdata_hold", {48'b0, rd_mdata}, {48'b0, m_hold_mdata});
            end
            chk("run_reqs_issued", {32'b0, run_reqs_issued}, {32'b0, m_issued});
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_resp();
        ctrl_resp_valid = 1'b1;
        step(1);
        ctrl_resp_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // Control polling, re-poll after the gap, then RUN pre-empting a poll
        ctrl_addr    = 42'h100;
        afu_state_in = 3'd1;
        step(10);
        pulse_resp();
        step(25);
        pulse_resp();
        step(5);
        ctrl_rd_addr = 42'h2000;
        ctrl_num_cls = 32'd4;
        afu_state_in = 3'd2;
        step(10);
        chk("run_cnt_4", {32'b0, run_reqs_issued}, 64'd4);
        afu_state_in = 3'd0;
        step(2);

        // Stall gap mid-burst
        ctrl_num_cls = 32'd6;
        afu_state_in = 3'd2;
        step(2);
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(8);
        chk("run_cnt_6", {32'b0, run_reqs_issued}, 64'd6);
        afu_state_in = 3'd0;
        step(2);

        // Address wrap
        ctrl_rd_addr = 42'h3FF_FFFF_FFFF;
        ctrl_num_cls = 32'd2;
        afu_state_in = 3'd2;
        step(5);
        afu_state_in = 3'd0;
        step(2);

        // Leave RUN mid-burst, then a fresh single-line run
        ctrl_rd_addr = 42'h4000;
        ctrl_num_cls = 32'd8;
        afu_state_in = 3'd2;
        step(3);
        afu_state_in = 3'd3;
        step(3);
        chk("run_cnt_abort", {32'b0, run_reqs_issued}, 64'd3);
        ctrl_rd_addr = 42'h5000;
        ctrl_num_cls = 32'd1;
        afu_state_in = 3'd2;
        step(4);
        chk("run_cnt_1", {32'b0, run_reqs_issued}, 64'd1);
        afu_state_in = 3'd0;
        step(2);

        // Reset mid-burst with RUN held, then fresh entry
        ctrl_rd_addr = 42'h6000;
        ctrl_num_cls = 32'd10;
        afu_state_in = 3'd2;
        step(3);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);
        chk("run_cnt_after_reset", {32'b0, run_reqs_issued}, 64'd0);
        afu_state_in = 3'd0;
        step(1);
        afu_state_in = 3'd2;
        step(12);
        afu_state_in = 3'd0;
        step(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) afu_state_in = 3'($urandom_range(0, 7));
            stall           = ($urandom_range(0, 3) == 0);
            ctrl_resp_valid = ($urandom_range(0, 7) == 0);
            r64             = {$urandom, $urandom};
            ctrl_addr       = r64[41:0];
            r64             = {$urandom, $urandom};
            ctrl_rd_addr    = ($urandom_range(0, 3) == 0) ?
                              (42'h3FF_FFFF_FFFC + 42'($urandom_range(0, 3))) : r64[41:0];
            ctrl_num_cls    = 32'($urandom_range(0, 6));
            step(1);
        end

        afu_state_in    = 3'd0;
        stall           = 1'b0;
        ctrl_resp_valid = 1'b0;
        step(5);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_engine.md
Name: read_engine

Overview:
- Generates cache-line read requests for the AFU's host read channel (c0 Tx).
- In the control phase it polls the host control word at ctrl_addr.
- In the run phase it streams num_cls sequential data-line reads starting at a host-supplied base address.
- Sits between the AFU state machine and the c0 header generator. Downstream logic registers rd_valid/rd_addr/rd_mdata into a request header; this block never builds headers itself.

Parameters:
- ADDR_W, 42, cache-line address width (t_ccip_clAddr).
- MDATA_W, 16, request metadata width.
- CNT_W, 32, line-count width.
- READ_CTRL_MDATA, 16'h0001, metadata tag for control-word reads.
- READ_RUN_MDATA, 16'h0002, metadata tag for run-phase data reads.
- POLL_GAP, 16, idle cycles between a control response and the next control poll.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  back-pressure (channel almost-full or response-FIFO overflow risk)
- afu_state_in  in  3  AFU state: IDLE=0, CTRL=1, RUN=2, DONE=3, SHUTDOWN_WAIT=4, SHUTDOWN=5
- ctrl_addr  in  ADDR_W  line address of host control word
- ctrl_resp_valid  in  1  one-cycle pulse: control-word read response arrived
- ctrl_rd_addr  in  ADDR_W  run base read address decoded from last control response
- ctrl_num_cls  in  CNT_W  run line count decoded from last control response
- rd_valid  out  1  request valid this cycle
- rd_mdata  out  MDATA_W  request metadata tag
- rd_addr  out  ADDR_W  request line address
- run_reqs_issued  out  CNT_W  data reads issued in current run

Behaviour:
- Reset (synchronous): rd_valid=0, rd_mdata=0, rd_addr=0, run_reqs_issued=0; internal poll FSM to P_IDLE; base/limit latches cleared.
- All outputs are registered. A request decided in cycle t appears at t+1 for exactly one cycle.
- stall is sampled in the decision cycle. If stall=1, no request is issued that cycle and nothing is lost; the same request is retried next cycle.
- rd_mdata/rd_addr hold their last value when rd_valid=0.
- Control poll FSM (active only while afu_state_in==CTRL):
  - P_IDLE: on entering CTRL, or state==CTRL with no request outstanding -> P_ISSUE.
  - P_ISSUE: when !stall, issue rd_valid=1, rd_addr=ctrl_addr, rd_mdata=READ_CTRL_MDATA -> P_WAIT.
  - P_WAIT: on ctrl_resp_valid -> P_GAP; load a counter with POLL_GAP.
  - P_GAP: counter decrements each cycle. At 0, if still CTRL -> P_ISSUE (re-poll: stale nonce or unrecognised code).
  - Leaving CTRL from any poll state -> P_IDLE.
  - Exactly one control read is outstanding at a time.
- Run phase:
  - On the cycle afu_state_in first equals RUN (previous sample != RUN), latch base=ctrl_rd_addr and limit=ctrl_num_cls; clear run_reqs_issued.
  - Each cycle in RUN with run_reqs_issued<limit and !stall: issue rd_addr=base+run_reqs_issued, rd_mdata=READ_RUN_MDATA; increment run_reqs_issued.
  - Maximum throughput is one request per cycle.
  - limit=0: no run requests are issued.
  - Address addition wraps modulo 2^ADDR_W.
  - run_reqs_issued saturates at limit.
  - If the state leaves RUN mid-burst, issuing stops immediately (no request in the following cycle). run_reqs_issued holds until the next RUN entry.
- IDLE, DONE, SHUTDOWN_WAIT, SHUTDOWN, and undefined encodings: no requests issued.
- ctrl_resp_valid outside P_WAIT is ignored.
- Reset asserted mid-burst: outputs clear the next cycle. Issuing resumes only on a fresh RUN entry after reset deasserts.

Test Plan:
- Reset, then state=CTRL with ctrl_addr=0x100 and stall=0 -> one cycle later rd_valid=1, rd_addr=0x100, rd_mdata=0x0001. No further request until a response arrives.
- In CTRL, pulse ctrl_resp_valid and hold CTRL -> second control read exactly POLL_GAP+1 cycles after the pulse. Changing state to RUN before then suppresses it.
- Enter RUN with ctrl_rd_addr=0x2000, ctrl_num_cls=4, stall=0 -> 4 consecutive rd_valid pulses at addresses 0x2000..0x2003, mdata 0x0002; run_reqs_issued=4; then rd_valid stays 0.
- RUN with num_cls=6, stall high for 3 cycles after the 2nd request -> 3-cycle gap, then addresses 0x2002..0x2005. No duplicates or skips; total 6.
- RUN with ctrl_rd_addr=0x3FF_FFFF_FFFF, num_cls=2 -> addresses 0x3FF_FFFF_FFFF then 0x000_0000_0000.
- num_cls=8, state forced to DONE after 3 requests -> no 4th request. Re-entering RUN with num_cls=1 -> single request at the newly latched base; run_reqs_issued=1.
